// File: rtl/dcache_controller_if.sv
// Bus bundle for dcache_controller: the CPU load/store port plus the
// block-level data_memory handshake. The cache uses the slave modport; the
// surrounding environment (CPU + data_memory) uses the master modport.
interface dcache_controller_if;

  // CPU side
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        busywait;

  // data_memory side
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

endinterface

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate data cache
// with 4-byte blocks. Read/write hits complete in IDLE with no stall; misses
// walk WRITEBACK (dirty victim only) -> ALLOCATE -> UPDATE and stall the CPU
// through busywait. Optional hit/miss statistics are enabled by defining the
// macro DCACHE_STATS_EN.
module dcache_controller #(
  parameter int INDEX_BITS = 3
) (
  input  logic                clock,
  input  logic                reset,
`ifdef DCACHE_STATS_EN
  output logic [15:0]         hit_count,
  output logic [15:0]         miss_count,
`endif
  dcache_controller_if.slave  bus
);

  localparam int TAG_BITS   = 6 - INDEX_BITS;
  localparam int NUM_BLOCKS = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  state_t                state_q;

  // Per-block storage; tags and data are qualified by valid and never reset
  logic [NUM_BLOCKS-1:0] valid_q;
  logic [NUM_BLOCKS-1:0] dirty_q;
  logic [TAG_BITS-1:0]   tag_q  [NUM_BLOCKS];
  logic [31:0]           data_q [NUM_BLOCKS];

  // Registered memory-side outputs and miss bookkeeping
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic [5:0]            mem_address_q;
  logic [31:0]           mem_writedata_q;
  logic                  req_issued_q;
  logic [31:0]           fill_q;
  logic [7:0]            readdata_q;

  // Address decode and hit/miss qualification
  logic [TAG_BITS-1:0]   addrTag;
  logic [INDEX_BITS-1:0] addrIndex;
  logic [1:0]            addrOffset;
  logic [4:0]            byteShift;
  logic [31:0]           lineData;
  logic [7:0]            selByte;
  logic                  access;
  logic                  idle;
  logic                  hit;
  logic                  readHit;
  logic                  writeHit;
  logic                  memDone;

  assign addrTag    = bus.address[7:2+INDEX_BITS];
  assign addrIndex  = bus.address[1+INDEX_BITS:2];
  assign addrOffset = bus.address[1:0];
  assign byteShift  = {addrOffset, 3'b000};

  // A request with both read and write high is not an access at all, and
  // nothing counts as an access while reset is held low.
  assign access   = reset && (bus.read ^ bus.write);
  assign idle     = (state_q == IDLE);
  assign lineData = data_q[addrIndex];
  assign selByte  = lineData[byteShift +: 8];
  assign hit      = valid_q[addrIndex] && (tag_q[addrIndex] == addrTag);
  assign readHit  = access && idle && hit && bus.read;
  assign writeHit = access && idle && hit && bus.write;

  // data_memory only raises its busywait after it has seen the request, so
  // the first edge in a memory state is skipped via req_issued_q.
  assign memDone  = req_issued_q && !bus.mem_busywait;

  assign bus.busywait      = access && !(idle && hit);
  assign bus.readdata      = readHit ? selByte : readdata_q;
  assign bus.mem_read      = mem_read_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_writedata = mem_writedata_q;

  // Miss-handling state machine; also owns valid/dirty bits and the
  // registered memory request outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      dirty_q         <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      req_issued_q    <= 1'b0;
      fill_q          <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          req_issued_q <= 1'b0;
          if (access && !hit) begin
            if (dirty_q[addrIndex]) begin
              state_q         <= WRITEBACK;
              mem_write_q     <= 1'b1;
              mem_address_q   <= {tag_q[addrIndex], addrIndex};
              mem_writedata_q <= lineData;
            end else begin
              state_q       <= ALLOCATE;
              mem_read_q    <= 1'b1;
              mem_address_q <= bus.address[7:2];
            end
          end else if (writeHit) begin
            dirty_q[addrIndex] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (!req_issued_q) begin
            req_issued_q <= 1'b1;
          end else if (memDone) begin
            state_q       <= ALLOCATE;
            req_issued_q  <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_read_q    <= 1'b1;
            mem_address_q <= bus.address[7:2];
          end
        end
        ALLOCATE: begin
          if (!req_issued_q) begin
            req_issued_q <= 1'b1;
          end else if (memDone) begin
            state_q      <= UPDATE;
            req_issued_q <= 1'b0;
            mem_read_q   <= 1'b0;
            fill_q       <= bus.mem_readdata;
          end
        end
        UPDATE: begin
          state_q            <= IDLE;
          valid_q[addrIndex] <= 1'b1;
          dirty_q[addrIndex] <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Block data and tag arrays: refill installs the fetched block, a write
  // hit merges the store byte into the resident block.
  always_ff @(posedge clock) begin
    if (reset && state_q == UPDATE) begin
      data_q[addrIndex] <= fill_q;
      tag_q[addrIndex]  <= addrTag;
    end else if (writeHit) begin
      data_q[addrIndex][byteShift +: 8] <= bus.writedata;
    end
  end

  // Holding register so readdata keeps the last load byte between read hits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      readdata_q <= 8'h00;
    end else if (readHit) begin
      readdata_q <= selByte;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count_q;
  logic [15:0] miss_count_q;
  logic        from_update_q;
  logic        hitEvent;
  logic        missEvent;

  // The IDLE cycle right after UPDATE finishes a miss already counted.
  assign hitEvent   = access && idle && hit && !from_update_q;
  assign missEvent  = access && idle && !hit;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  // Saturating hit/miss counters, one count per accepted access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count_q   <= '0;
      miss_count_q  <= '0;
      from_update_q <= 1'b0;
    end else begin
      from_update_q <= (state_q == UPDATE);
      if (hitEvent && hit_count_q != 16'hFFFF) begin
        hit_count_q <= hit_count_q + 16'd1;
      end
      if (missEvent && miss_count_q != 16'hFFFF) begin
        miss_count_q <= miss_count_q + 16'd1;
      end
    end
  end
`else
  // Statistics disabled: no counters and no extra ports.
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: a table of CPU accesses with
// expected readdata and stall behaviour, a reference cache model that queues
// the expected data_memory transactions, a behavioural data_memory, and a few
// hand-written sequences for reset and read&&write corner cases.
module tb_dcache_controller;

  localparam int MEM_LATENCY = 3;
  localparam int TIMEOUT     = 200;

  logic clock;
  logic reset;

  dcache_controller_if bus ();

`ifdef DCACHE_STATS_EN
  logic [15:0] hitCount;
  logic [15:0] missCount;
`endif

  dcache_controller #(.INDEX_BITS(3)) dut (
    .clock      (clock),
    .reset      (reset),
`ifdef DCACHE_STATS_EN
    .hit_count  (hitCount),
    .miss_count (missCount),
`endif
    .bus        (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       isWrite;
    logic [5:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wd;
    logic       expMiss;
    logic [7:0] expRd;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  txn_t expQ[$];
  txn_t actQ[$];
  int   actIdx   = 0;
  bit   bothHighSeen = 1'b0;

  // Initial memory image: block i holds byte i replicated, except block 1
  function automatic logic [31:0] initVal(input logic [5:0] a);
    if (a == 6'h01) return 32'h44332211;
    return {4{2'b00, a}};
  endfunction

  // Behavioural data_memory: accepts a request, stays busy MEM_LATENCY
  // cycles, then performs it; ignores the edge right after completing.
  bit [31:0]   memData    [64];
  bit          memWritten [64];
  logic        memBusy;
  logic        memCool;
  int          memCnt;
  logic        opWrite;
  logic [5:0]  opAddr;
  logic [31:0] opData;

  assign bus.mem_busywait = memBusy;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      memBusy          <= 1'b0;
      memCool          <= 1'b0;
      memCnt           <= 0;
      bus.mem_readdata <= 32'h0;
    end else begin
      memCool <= 1'b0;
      if (memBusy) begin
        if (memCnt == 1) begin
          memBusy <= 1'b0;
          memCool <= 1'b1;
          if (opWrite) begin
            memData[opAddr]    <= opData;
            memWritten[opAddr] <= 1'b1;
          end else begin
            bus.mem_readdata <= memWritten[opAddr] ? memData[opAddr] : initVal(opAddr);
          end
        end
        memCnt <= memCnt - 1;
      end else if (!memCool && (bus.mem_read || bus.mem_write)) begin
        memBusy <= 1'b1;
        memCnt  <= MEM_LATENCY;
        opWrite <= bus.mem_write;
        opAddr  <= bus.mem_address;
        opData  <= bus.mem_writedata;
        actQ.push_back('{isWrite: bus.mem_write, addr: bus.mem_address, data: bus.mem_writedata});
      end
    end
  end

  // Watch for the forbidden simultaneous read/write request
  always @(negedge clock) begin
    if (bus.mem_read && bus.mem_write) bothHighSeen <= 1'b1;
  end

  // Reference cache model state
  logic        refValid [8];
  logic        refDirty [8];
  logic [2:0]  refTag   [8];
  logic [31:0] refData  [8];
  logic [31:0] refMem   [64];

  task automatic modelReset();
    for (int i = 0; i < 8; i++) begin
      refValid[i] = 1'b0;
      refDirty[i] = 1'b0;
    end
  endtask

  // Predict the memory traffic of one access and update the model
  task automatic modelAccess(input logic rd, input logic wr, input logic [7:0] addr, input logic [7:0] wd);
    logic [2:0] idx;
    logic [2:0] tg;
    idx = addr[4:2];
    tg  = addr[7:5];
    if (rd ^ wr) begin
      if (!(refValid[idx] && refTag[idx] == tg)) begin
        if (refValid[idx] && refDirty[idx]) begin
          expQ.push_back('{isWrite: 1'b1, addr: {refTag[idx], idx}, data: refData[idx]});
          refMem[{refTag[idx], idx}] = refData[idx];
        end
        expQ.push_back('{isWrite: 1'b0, addr: addr[7:2], data: 32'h0});
        refData[idx]  = refMem[addr[7:2]];
        refTag[idx]   = tg;
        refValid[idx] = 1'b1;
        refDirty[idx] = 1'b0;
      end
      if (wr) begin
        refData[idx][8*addr[1:0] +: 8] = wd;
        refDirty[idx] = 1'b1;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // Pop expected transactions and compare with what the memory observed
  task automatic checkTraffic(input string name);
    txn_t e;
    txn_t a;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      if (actIdx >= actQ.size()) begin
        checks++;
        failures++;
        $display("[TB] FAIL %s missing_txn actual=none required=%s@%h", name, e.isWrite ? "W" : "R", e.addr);
      end else begin
        a = actQ[actIdx];
        actIdx++;
        checkOutput({name, "_txn_kind"}, 32'(a.isWrite), 32'(e.isWrite));
        checkOutput({name, "_txn_addr"}, 32'(a.addr), 32'(e.addr));
        if (e.isWrite) checkOutput({name, "_txn_data"}, a.data, e.data);
      end
    end
    checkOutput({name, "_extra_txns"}, 32'(actQ.size() - actIdx), 32'd0);
  endtask

  // Wait (bounded) for busywait to drop, sampling on negedges
  task automatic waitReady(input string name);
    int cyc;
    cyc = 0;
    while (bus.busywait && cyc < TIMEOUT) begin
      @(negedge clock);
      cyc++;
    end
    if (bus.busywait) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout actual=busy required=ready", name);
    end
  endtask

  // Drive one CPU access, check stall flag, completion data and traffic
  task automatic applyStimulus(input vec_t v, input string name);
    modelAccess(v.rd, v.wr, v.addr, v.wd);
    @(posedge clock);
    #1;
    bus.read      = v.rd;
    bus.write     = v.wr;
    bus.address   = v.addr;
    bus.writedata = v.wd;
    @(negedge clock);
    checkOutput({name, "_busywait"}, 32'(bus.busywait), 32'(v.expMiss));
    waitReady(name);
    checkOutput({name, "_readdata"}, 32'(bus.readdata), 32'(v.expRd));
    @(posedge clock);
    #1;
    bus.read  = 1'b0;
    bus.write = 1'b0;
    checkTraffic(name);
  endtask

  vec_t vecs[10];
  int   cyc;

  initial begin
    vecs[0] = '{rd: 1, wr: 0, addr: 8'h05, wd: 8'h00, expMiss: 1, expRd: 8'h22};
    vecs[1] = '{rd: 1, wr: 0, addr: 8'h07, wd: 8'h00, expMiss: 0, expRd: 8'h44};
    vecs[2] = '{rd: 0, wr: 1, addr: 8'h05, wd: 8'hAB, expMiss: 0, expRd: 8'h44};
    vecs[3] = '{rd: 1, wr: 0, addr: 8'h25, wd: 8'h00, expMiss: 1, expRd: 8'h09};
    vecs[4] = '{rd: 1, wr: 0, addr: 8'h45, wd: 8'h00, expMiss: 1, expRd: 8'h11};
    vecs[5] = '{rd: 1, wr: 0, addr: 8'h04, wd: 8'h00, expMiss: 1, expRd: 8'h11};
    vecs[6] = '{rd: 0, wr: 1, addr: 8'h2A, wd: 8'h5A, expMiss: 1, expRd: 8'h11};
    vecs[7] = '{rd: 1, wr: 0, addr: 8'h0A, wd: 8'h00, expMiss: 1, expRd: 8'h02};
    vecs[8] = '{rd: 1, wr: 0, addr: 8'h2A, wd: 8'h00, expMiss: 1, expRd: 8'h5A};
    vecs[9] = '{rd: 1, wr: 0, addr: 8'h29, wd: 8'h00, expMiss: 0, expRd: 8'h0A};

    for (int i = 0; i < 64; i++) refMem[i] = initVal(6'(i));
    modelReset();

    // Reset state, including busywait forced low with a request pending
    reset         = 1'b0;
    bus.read      = 1'b1;
    bus.write     = 1'b0;
    bus.address   = 8'h05;
    bus.writedata = 8'h00;
    #23;
    checkOutput("reset_busywait", 32'(bus.busywait), 32'd0);
    checkOutput("reset_readdata", 32'(bus.readdata), 32'd0);
    checkOutput("reset_mem_read", 32'(bus.mem_read), 32'd0);
    checkOutput("reset_mem_write", 32'(bus.mem_write), 32'd0);
`ifdef DCACHE_STATS_EN
    checkOutput("reset_hit_count", 32'(hitCount), 32'd0);
    checkOutput("reset_miss_count", 32'(missCount), 32'd0);
`endif
    bus.read = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    // Table-driven accesses
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
`ifdef DCACHE_STATS_EN
      if (i == 4) begin
        checkOutput("stats_hit_after_t4", 32'(hitCount), 32'd2);
        checkOutput("stats_miss_after_t4", 32'(missCount), 32'd3);
      end
`endif
    end
`ifdef DCACHE_STATS_EN
    checkOutput("stats_hit_after_table", 32'(hitCount), 32'd3);
    checkOutput("stats_miss_after_table", 32'(missCount), 32'd7);
`endif

    // read && write together: ignored, no stall, no traffic, no state change
    @(posedge clock);
    #1;
    bus.read      = 1'b1;
    bus.write     = 1'b1;
    bus.address   = 8'h06;
    bus.writedata = 8'hFF;
    @(negedge clock);
    checkOutput("rw_both_busywait", 32'(bus.busywait), 32'd0);
    checkOutput("rw_both_readdata", 32'(bus.readdata), 32'h0A);
    repeat (3) @(posedge clock);
    #1;
    bus.read  = 1'b0;
    bus.write = 1'b0;
    checkOutput("rw_both_traffic", 32'(actQ.size() - actIdx), 32'd0);
`ifdef DCACHE_STATS_EN
    checkOutput("rw_both_hit_count", 32'(hitCount), 32'd3);
    checkOutput("rw_both_miss_count", 32'(missCount), 32'd7);
`endif
    applyStimulus('{rd: 1, wr: 0, addr: 8'h06, wd: 8'h00, expMiss: 0, expRd: 8'h33}, "rw_both_after");

    // Reset asserted while the cache is allocating
    @(posedge clock);
    #1;
    bus.read    = 1'b1;
    bus.address = 8'h85;
    cyc = 0;
    @(negedge clock);
    while (!bus.mem_read && cyc < TIMEOUT) begin
      @(negedge clock);
      cyc++;
    end
    checkOutput("alloc_mem_read_seen", 32'(bus.mem_read), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("alloc_reset_mem_read", 32'(bus.mem_read), 32'd0);
    checkOutput("alloc_reset_busywait", 32'(bus.busywait), 32'd0);
    checkOutput("alloc_reset_readdata", 32'(bus.readdata), 32'd0);
`ifdef DCACHE_STATS_EN
    checkOutput("alloc_reset_hit_count", 32'(hitCount), 32'd0);
`endif
    bus.read = 1'b0;
    modelReset();
    @(negedge clock);
    reset = 1'b1;
    checkOutput("alloc_reset_traffic", 32'(actQ.size() - actIdx), 32'd0);
    applyStimulus('{rd: 1, wr: 0, addr: 8'h05, wd: 8'h00, expMiss: 1, expRd: 8'hAB}, "reread_after_reset");

    checkOutput("mem_rw_exclusive", 32'(bothHighSeen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
